// File: rtl/instruction_encoder_pkg.sv
// Shared definitions for the instruction encoder and its field packer.
// Holds opcodes, funct codes, field widths, immediate limits, error codes and FSM states.
// Pure declarations: no logic, no latency, no flow control.
package instruction_encoder_pkg;

    localparam int OP_W    = 4;
    localparam int REG_W   = 4;
    localparam int FUNCT_W = 4;
    localparam int IMM_W   = 12;
    localparam int WORD_W  = 16;

    // Opcodes; 0011, 1000, 1001 and 1110 are reserved and rejected.
    localparam logic [OP_W-1:0] OP_RTYPE = 4'b0000;
    localparam logic [OP_W-1:0] OP_AND   = 4'b0001;
    localparam logic [OP_W-1:0] OP_OR    = 4'b0010;
    localparam logic [OP_W-1:0] OP_BGT   = 4'b0100;
    localparam logic [OP_W-1:0] OP_BLT   = 4'b0101;
    localparam logic [OP_W-1:0] OP_BEQ   = 4'b0110;
    localparam logic [OP_W-1:0] OP_JUMP  = 4'b0111;
    localparam logic [OP_W-1:0] OP_LBU   = 4'b1010;
    localparam logic [OP_W-1:0] OP_SB    = 4'b1011;
    localparam logic [OP_W-1:0] OP_LW    = 4'b1100;
    localparam logic [OP_W-1:0] OP_SW    = 4'b1101;
    localparam logic [OP_W-1:0] OP_HALT  = 4'b1111;

    // R-type function codes understood by the control unit (passed through untouched).
    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 4'h0;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 4'h1;
    localparam logic [FUNCT_W-1:0] FUNCT_SLL = 4'h2;
    localparam logic [FUNCT_W-1:0] FUNCT_SRL = 4'h3;
    localparam logic [FUNCT_W-1:0] FUNCT_XOR = 4'h4;

    // Legal immediate ranges, expressed at full immediate width for signed compares.
    localparam logic signed [IMM_W-1:0] IMM_LOGIC_MIN = 12'sd0;
    localparam logic signed [IMM_W-1:0] IMM_LOGIC_MAX = 12'sd255;
    localparam logic signed [IMM_W-1:0] IMM_BR_MIN    = -12'sd128;
    localparam logic signed [IMM_W-1:0] IMM_BR_MAX    = 12'sd127;
    localparam logic signed [IMM_W-1:0] IMM_MEM_MIN   = -12'sd8;
    localparam logic signed [IMM_W-1:0] IMM_MEM_MAX   = 12'sd7;

    localparam logic [WORD_W-1:0] HALT_WORD = 16'hF000;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_OPCODE = 2'b01;
    localparam logic [1:0] ERR_IMM    = 2'b10;
    localparam logic [1:0] ERR_OVF    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10,
        S_ERR  = 2'b11
    } state_t;

endpackage

// File: rtl/instr_field_pack.sv
// Packs one instruction request into a 16-bit word and flags illegal opcodes / immediates.
// Purely combinational: zero latency.
// No flow control; the caller decides when the result is consumed.
module instr_field_pack
    import instruction_encoder_pkg::*;
(
    input  logic [OP_W-1:0]    op,
    input  logic [REG_W-1:0]   op1,
    input  logic [REG_W-1:0]   op2,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [IMM_W-1:0]   imm,
    output logic [WORD_W-1:0]  word,
    output logic               illegal_op,
    output logic               imm_err,
    output logic               is_halt
);

    logic signed [IMM_W-1:0] simm;
    assign simm = $signed(imm);

    // Per-opcode field layout and range check; fields an opcode does not use are ignored.
    always_comb begin
        word       = '0;
        illegal_op = 1'b0;
        imm_err    = 1'b0;
        is_halt    = 1'b0;
        case (op)
            OP_RTYPE: word = {op, op1, op2, funct};
            OP_AND, OP_OR: begin
                word    = {op, op1, imm[7:0]};
                imm_err = (simm < IMM_LOGIC_MIN) || (simm > IMM_LOGIC_MAX);
            end
            OP_BGT, OP_BLT, OP_BEQ: begin
                word    = {op, op1, imm[7:0]};
                imm_err = (simm < IMM_BR_MIN) || (simm > IMM_BR_MAX);
            end
            OP_JUMP: word = {op, imm};
            OP_LBU, OP_SB, OP_LW, OP_SW: begin
                word    = {op, op1, imm[3:0], op2};
                imm_err = (simm < IMM_MEM_MIN) || (simm > IMM_MEM_MAX);
            end
            OP_HALT: begin
                word    = HALT_WORD;
                is_halt = 1'b1;
            end
            default: illegal_op = 1'b1;
        endcase
    end

endmodule

// File: rtl/instruction_encoder.sv
// Accepts instruction requests, encodes them and writes them to consecutive memory words.
// Latency: one cycle from accepted request to mem_we; one write per cycle sustained.
// Backpressure: in_ready low outside RUN, when full, during start, and while a HALT write is pending.
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [3:0]        in_op1,
    input  logic [3:0]        in_op2,
    input  logic [3:0]        in_funct,
    input  logic [11:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              error,
    output logic [1:0]        err_code
);

    localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic              halt_pending;
    logic [15:0]       enc_word;
    logic              illegal_op, imm_err, is_halt;
    logic              accept, wr, last_addr;

    instr_field_pack u_pack (
        .op         (in_op),
        .op1        (in_op1),
        .op2        (in_op2),
        .funct      (in_funct),
        .imm        (in_imm),
        .word       (enc_word),
        .illegal_op (illegal_op),
        .imm_err    (imm_err),
        .is_halt    (is_halt)
    );

    assign in_ready  = (state == S_RUN) && !full && !start && !halt_pending;
    assign accept    = in_valid && in_ready;
    assign wr        = accept && !illegal_op && !imm_err;
    assign last_addr = &ptr;

    assign busy  = (state == S_RUN);
    assign done  = (state == S_DONE);
    assign error = (state == S_ERR);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next state: start always wins; errors and overflow are decided at accept time,
    // DONE waits until the HALT word has actually been driven to memory.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = S_RUN;
        end else if (state == S_RUN) begin
            if (accept && (illegal_op || imm_err))  state_nxt = S_ERR;
            else if (wr && last_addr && !is_halt)   state_nxt = S_ERR;
            else if (halt_pending)                  state_nxt = S_DONE;
        end
    end

    // Write register, pointer, count and sticky error/full flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            ptr          <= '0;
            word_count   <= '0;
            full         <= 1'b0;
            err_code     <= ERR_NONE;
            halt_pending <= 1'b0;
        end else begin
            // A write launched last cycle is already on the port, so start cannot cancel it.
            mem_we <= wr;
            if (start) begin
                ptr          <= base_addr;
                word_count   <= '0;
                full         <= 1'b0;
                err_code     <= ERR_NONE;
                halt_pending <= 1'b0;
            end else begin
                halt_pending <= wr && is_halt;
                if (accept && illegal_op) begin
                    err_code <= ERR_OPCODE;
                end else if (accept && imm_err) begin
                    err_code <= ERR_IMM;
                end else if (wr) begin
                    mem_addr  <= ptr;
                    mem_wdata <= enc_word;
                    ptr       <= ptr + ADDR_W'(1);
                    if (word_count != COUNT_MAX)
                        word_count <= word_count + (ADDR_W+1)'(1);
                    // Last address consumed: stop before the pointer wraps.
                    if (last_addr) begin
                        full <= 1'b1;
                        if (!is_halt) err_code <= ERR_OVF;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
module tb_instruction_encoder;
    import instruction_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [7:0]  base_addr;
    logic [3:0]  in_op, in_op1, in_op2, in_funct;
    logic [11:0] in_imm;

    logic        in_ready, mem_we, busy, done, full, error;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [8:0]  word_count;
    logic [1:0]  err_code;

    logic        s_in_ready, s_mem_we, s_busy, s_done, s_full, s_error;
    logic [1:0]  s_mem_addr;
    logic [15:0] s_mem_wdata;
    logic [2:0]  s_word_count;
    logic [1:0]  s_err_code;

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] got_q[$];
    logic [23:0] s_got_q[$];
    logic [23:0] exp_q[$];

    instruction_encoder #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_op1(in_op1), .in_op2(in_op2), .in_funct(in_funct), .in_imm(in_imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .word_count(word_count),
        .busy(busy), .done(done), .full(full), .error(error), .err_code(err_code)
    );

    instruction_encoder #(.ADDR_W(2)) dut_small (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr[1:0]),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_op(in_op), .in_op1(in_op1), .in_op2(in_op2), .in_funct(in_funct), .in_imm(in_imm),
        .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .word_count(s_word_count),
        .busy(s_busy), .done(s_done), .full(s_full), .error(s_error), .err_code(s_err_code)
    );

    always #5 clk = ~clk;

    // Write monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we)   got_q.push_back({mem_addr, mem_wdata});
        if (s_mem_we) s_got_q.push_back({6'b0, s_mem_addr, s_mem_wdata});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] b);
        start = 1'b1; base_addr = b; in_valid = 1'b0;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] f, input logic [11:0] imm, output bit acc);
        in_valid = 1'b1; in_op = op; in_op1 = a; in_op2 = b; in_funct = f; in_imm = imm;
        #1;
        acc = in_ready;
        tick();
        in_valid = 1'b0;
    endtask

    // Reference encoder from the instruction-set rules: err 0 ok, 1 bad opcode, 2 bad immediate.
    function automatic void ref_encode(input int op, input int op1, input int op2, input int funct,
                                       input int imm12, output int word, output int err, output bit halt);
        int s;
        s = (imm12 >= 2048) ? imm12 - 4096 : imm12;
        word = 0; err = 0; halt = 1'b0;
        case (op)
            0:       word = op1 * 256 + op2 * 16 + funct;
            1, 2:    if (s < 0 || s > 255) err = 2; else word = op * 4096 + op1 * 256 + s;
            4, 5, 6: if (s < -128 || s > 127) err = 2; else word = op * 4096 + op1 * 256 + (s & 255);
            7:       word = 7 * 4096 + imm12;
            10, 11, 12, 13:
                     if (s < -8 || s > 7) err = 2; else word = op * 4096 + op1 * 256 + (s & 15) * 16 + op2;
            15:      begin word = 'hF000; halt = 1'b1; end
            default: err = 1;
        endcase
    endfunction

    task automatic compare_writes(input string tag);
        int n;
        check({tag, "_nwr"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_wr"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        bit acc;
        int legal_ops[12] = '{0, 1, 2, 4, 5, 6, 7, 10, 11, 12, 13, 15};

        rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0;
        in_op = '0; in_op1 = '0; in_op2 = '0; in_funct = '0; in_imm = '0;
        repeat (2) tick();
        check("rst_ready", in_ready, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_count", word_count, 0);
        check("rst_flags", {busy, done, full, error}, 0);
        check("rst_errcode", err_code, 0);
        rst = 1'b0;
        tick();
        check("idle_ready", in_ready, 0);

        // First R-type write lands at the base address one cycle after acceptance.
        do_start(8'h10);
        got_q.delete();
        check("run_busy", busy, 1);
        send(OP_RTYPE, 4'd1, 4'd2, FUNCT_XOR, 12'h0, acc);
        check("r_acc", acc, 1);
        check("r_we", mem_we, 1);
        check("r_addr", mem_addr, 8'h10);
        check("r_wdata", mem_wdata, 16'h0124);
        check("r_count", word_count, 1);

        // AND with max immediate, then OR out of range.
        send(OP_AND, 4'd3, 4'd9, 4'd7, 12'h0FF, acc);
        check("and_wdata", mem_wdata, 16'h13FF);
        check("and_addr", mem_addr, 8'h11);
        send(OP_OR, 4'd3, 4'd0, 4'd0, 12'h100, acc);
        check("or_acc", acc, 1);
        check("or_we", mem_we, 0);
        check("or_error", error, 1);
        check("or_errcode", err_code, ERR_IMM);
        check("or_ready", in_ready, 0);
        exp_q.push_back({8'h10, 16'h0124});
        exp_q.push_back({8'h11, 16'h13FF});
        compare_writes("imm");

        // Back-to-back mixed formats ending in HALT.
        do_start(8'h00);
        got_q.delete();
        send(OP_LW, 4'd2, 4'd5, 4'd9, 12'hFFF, acc);
        send(OP_BEQ, 4'd1, 4'd7, 4'd3, 12'hFFE, acc);
        send(OP_JUMP, 4'd5, 4'd6, 4'd2, 12'h800, acc);
        send(OP_HALT, 4'd9, 4'd1, 4'd4, 12'h123, acc);
        check("halt_acc", acc, 1);
        check("halt_wdata", mem_wdata, 16'hF000);
        check("halt_pend_ready", in_ready, 0);
        tick();
        check("halt_done", done, 1);
        check("halt_busy", busy, 0);
        check("halt_error", error, 0);
        check("halt_count", word_count, 4);
        exp_q.push_back({8'h00, 16'hC2F5});
        exp_q.push_back({8'h01, 16'h61FE});
        exp_q.push_back({8'h02, 16'h7800});
        exp_q.push_back({8'h03, 16'hF000});
        compare_writes("seq");

        // Illegal opcode, then recovery via start.
        do_start(8'h00);
        got_q.delete();
        send(4'b1000, 4'd1, 4'd1, 4'd1, 12'h0, acc);
        check("ill_error", error, 1);
        check("ill_errcode", err_code, ERR_OPCODE);
        check("ill_we", mem_we, 0);
        do_start(8'h20);
        check("restart_busy", busy, 1);
        check("restart_error", error, 0);
        check("restart_errcode", err_code, 0);
        check("restart_count", word_count, 0);
        compare_writes("ill");

        // start with in_valid high: request refused, in-flight write still completes.
        send(OP_RTYPE, 4'd4, 4'd4, FUNCT_ADD, 12'h0, acc);
        start = 1'b1; base_addr = 8'h40; in_valid = 1'b1;
        in_op = OP_RTYPE; in_op1 = 4'd7; in_op2 = 4'd7; in_funct = FUNCT_SUB;
        #1;
        check("start_prio_ready", in_ready, 0);
        check("start_prio_we", mem_we, 1);
        tick();
        start = 1'b0; in_valid = 1'b0;
        check("start_prio_count", word_count, 0);
        check("start_prio_we2", mem_we, 0);
        send(OP_RTYPE, 4'd8, 4'd8, FUNCT_SLL, 12'h0, acc);
        tick();
        exp_q.push_back({8'h20, 16'h0440});
        exp_q.push_back({8'h40, 16'h0882});
        compare_writes("prio");

        // Small memory: four words fill it, the fifth must not wrap.
        do_start(8'h00);
        s_got_q.delete();
        for (int i = 0; i < 4; i++) send(OP_RTYPE, 4'(i), 4'd1, FUNCT_ADD, 12'h0, acc);
        tick();
        check("ovf_full", s_full, 1);
        check("ovf_error", s_error, 1);
        check("ovf_errcode", s_err_code, ERR_OVF);
        check("ovf_ready", s_in_ready, 0);
        check("ovf_count", s_word_count, 4);
        send(OP_RTYPE, 4'd9, 4'd9, FUNCT_ADD, 12'h0, acc);
        repeat (2) tick();
        check("ovf_nwr", s_got_q.size(), 4);
        for (int i = 0; i < 4 && i < s_got_q.size(); i++)
            check("ovf_wr", s_got_q[i], {8'(i), 4'h0, 4'(i), 4'h1, 4'h0});

        // HALT into the last slot of the small memory.
        do_start(8'h00);
        for (int i = 0; i < 3; i++) send(OP_RTYPE, 4'd1, 4'd1, FUNCT_ADD, 12'h0, acc);
        send(OP_HALT, 4'd0, 4'd0, 4'd0, 12'h0, acc);
        tick();
        check("lasthalt_done", s_done, 1);
        check("lasthalt_full", s_full, 1);
        check("lasthalt_error", s_error, 0);

        // Reset right after an accept drops the pending write.
        do_start(8'h30);
        got_q.delete();
        send(OP_RTYPE, 4'd2, 4'd3, FUNCT_ADD, 12'h0, acc);
        rst = 1'b1;
        #1;
        check("mrst_we", mem_we, 0);
        check("mrst_addr", mem_addr, 0);
        check("mrst_wdata", mem_wdata, 0);
        check("mrst_count", word_count, 0);
        check("mrst_flags", {in_ready, busy, done, full, error, err_code}, 0);
        tick();
        rst = 1'b0;
        in_valid = 1'b1; in_op = OP_RTYPE;
        repeat (3) tick();
        check("mrst_idle_ready", in_ready, 0);
        in_valid = 1'b0;
        check("mrst_nwr", got_q.size(), 0);
        got_q.delete();

        // Randomised sessions against the reference encoder.
        for (int s = 0; s < 25; s++) begin
            int base, n, cnt, exp_err, word, err;
            bit ended, exp_done, halt;
            base = $urandom_range(0, 200);
            do_start(8'(base));
            got_q.delete(); exp_q.delete();
            n = $urandom_range(1, 12);
            cnt = 0; exp_err = 0; ended = 1'b0; exp_done = 1'b0;
            for (int i = 0; i < n && !ended; i++) begin
                int op, imm;
                op = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : legal_ops[$urandom_range(0, 11)];
                case ($urandom_range(0, 3))
                    0: imm = $urandom_range(0, 4095);
                    1: imm = ($urandom_range(0, 255) - 128) & 4095;
                    2: imm = $urandom_range(0, 255);
                    default: imm = ($urandom_range(0, 15) - 8) & 4095;
                endcase
                if ($urandom_range(0, 2) == 0) tick();
                ref_encode(op, int'(in_op1), 0, 0, 0, word, err, halt);
                in_op1 = 4'($urandom); in_op2 = 4'($urandom); in_funct = 4'($urandom);
                ref_encode(op, int'(in_op1), int'(in_op2), int'(in_funct), imm, word, err, halt);
                send(4'(op), in_op1, in_op2, in_funct, 12'(imm), acc);
                check("rnd_acc", acc, 1);
                if (err != 0) begin
                    exp_err = err;
                    ended = 1'b1;
                end else begin
                    exp_q.push_back({8'(base + cnt), 16'(word)});
                    cnt++;
                    if (halt) begin
                        exp_done = 1'b1;
                        ended = 1'b1;
                    end
                end
            end
            repeat (2) tick();
            compare_writes("rnd");
            check("rnd_count", word_count, cnt);
            check("rnd_error", error, exp_err != 0);
            check("rnd_errcode", err_code, exp_err);
            check("rnd_done", done, exp_done);
            check("rnd_busy", busy, !ended);
            check("rnd_full", full, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
